// File: rtl/mem_io_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_io_responder
// Brief    : Byte-wide RAM model with a memory-mapped UART TX/RX FIFO window.
// Revision : 1.0 - initial release
// ============================================================================
module mem_io_responder #(
  parameter int ADDR_BITS = 17,
  parameter int TX_DEPTH  = 8,
  parameter int RX_DEPTH  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready
);

  localparam int c_tx_aw = $clog2(TX_DEPTH);
  localparam int c_rx_aw = $clog2(RX_DEPTH);
  localparam logic [c_tx_aw:0] c_tx_full  = (c_tx_aw+1)'(TX_DEPTH);
  localparam logic [c_tx_aw:0] c_tx_high  = (c_tx_aw+1)'(TX_DEPTH - 1);
  localparam logic [c_rx_aw:0] c_rx_full  = (c_rx_aw+1)'(RX_DEPTH);
  localparam logic [17:0]      c_a_data   = 18'h30000;
  localparam logic [17:0]      c_a_status = 18'h30004;

  logic [7:0]           r_ram [2**ADDR_BITS];
  logic [7:0]           r_tx_mem [TX_DEPTH];
  logic [7:0]           r_rx_mem [RX_DEPTH];
  logic [c_tx_aw-1:0]   r_tx_wp, r_tx_rp;
  logic [c_tx_aw:0]     r_tx_count;
  logic [c_rx_aw-1:0]   r_rx_wp, r_rx_rp;
  logic [c_rx_aw:0]     r_rx_count;
  logic                 r_tx_ovf;
  logic [7:0]           r_din;

  logic                 w_io, w_is_data, w_is_status;
  logic                 w_ram_wr;
  logic [ADDR_BITS-1:0] w_idx;
  logic                 w_tx_wr, w_tx_full, w_tx_push, w_tx_pop, w_tx_drop;
  logic                 w_rx_nonempty, w_rx_push, w_rx_pop;
  logic                 w_unused;

  // Upper address bits are outside the decoded space.
  assign w_unused    = ^mem_a[31:18];

  assign w_io        = (mem_a[17:16] == 2'b11);
  assign w_is_data   = (mem_a[17:0] == c_a_data);
  assign w_is_status = (mem_a[17:0] == c_a_status);
  assign w_idx       = mem_a[ADDR_BITS-1:0];
  assign w_ram_wr    = mem_wr && !w_io;

  assign w_tx_full   = (r_tx_count == c_tx_full);
  assign w_tx_pop    = tx_valid && tx_ready;
  assign w_tx_wr     = mem_wr && w_is_data;
  // A same-cycle pop frees the slot, so a write to a full FIFO still lands.
  assign w_tx_push   = w_tx_wr && (!w_tx_full || w_tx_pop);
  assign w_tx_drop   = w_tx_wr && w_tx_full && !w_tx_pop;

  assign w_rx_nonempty = (r_rx_count != '0);
  assign w_rx_push     = rx_valid && rx_ready;
  assign w_rx_pop      = !mem_wr && w_is_data && w_rx_nonempty;

  assign io_buffer_full = (r_tx_count >= c_tx_high);
  assign tx_valid       = (r_tx_count != '0);
  assign tx_data        = tx_valid ? r_tx_mem[r_tx_rp] : 8'h00;
  assign rx_ready       = (r_rx_count != c_rx_full);
  assign mem_din        = r_din;

  // Storage arrays carry no reset; only pointers and counts qualify them.
  always_ff @(posedge clk) begin
    if (w_ram_wr)  r_ram[w_idx]       <= mem_dout;
    if (w_tx_push) r_tx_mem[r_tx_wp]  <= mem_dout;
    if (w_rx_push) r_rx_mem[r_rx_wp]  <= rx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_din <= 8'h00;
    end else if (!mem_wr) begin
      if (!w_io)
        r_din <= r_ram[w_idx];
      else if (w_is_data)
        r_din <= w_rx_nonempty ? r_rx_mem[r_rx_rp] : 8'h00;
      else if (w_is_status)
        r_din <= {5'b0, r_tx_ovf, w_rx_nonempty, io_buffer_full};
      else
        r_din <= 8'h00;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_wp    <= '0;
      r_tx_rp    <= '0;
      r_tx_count <= '0;
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_count <= r_tx_count + 1'b1;
        2'b01:   r_tx_count <= r_tx_count - 1'b1;
        default: r_tx_count <= r_tx_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_wp    <= '0;
      r_rx_rp    <= '0;
      r_rx_count <= '0;
    end else begin
      if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_count <= r_rx_count + 1'b1;
        2'b01:   r_rx_count <= r_rx_count - 1'b1;
        default: r_rx_count <= r_rx_count;
      endcase
    end
  end

  // Overflow is sticky; a drop in the same cycle as a STATUS read wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_tx_ovf <= 1'b0;
    else if (w_tx_drop)
      r_tx_ovf <= 1'b1;
    else if (!mem_wr && w_is_status)
      r_tx_ovf <= 1'b0;
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_io_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_io_responder
// Brief    : Scoreboard bench for mem_io_responder against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_io_responder;

  localparam int TXD = 8;
  localparam int RXD = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mem_a = '0;
  logic        mem_wr = 1'b0;
  logic [7:0]  mem_dout = '0;
  logic [7:0]  mem_din;
  logic        io_buffer_full, tx_valid, rx_ready;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;

  always #5 clk = ~clk;

  mem_io_responder #(.ADDR_BITS(17), .TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
    .clk(clk), .rst(rst), .mem_a(mem_a), .mem_wr(mem_wr), .mem_dout(mem_dout),
    .mem_din(mem_din), .io_buffer_full(io_buffer_full), .tx_valid(tx_valid),
    .tx_data(tx_data), .tx_ready(tx_ready), .rx_valid(rx_valid),
    .rx_data(rx_data), .rx_ready(rx_ready)
  );

  // Reference model: RAM as a sparse map, FIFOs as plain queues.
  logic [7:0] ram_m [int];
  logic [7:0] tx_q [$];
  logic [7:0] rx_q [$];
  bit         ovf_m = 1'b0;

  typedef struct { int c; logic [7:0] v; } exp_t;
  exp_t       exp_q [$];
  logic [7:0] held = 8'h00;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic       drv_txr = 1'b0;
  logic       drv_rxv = 1'b0;
  logic [7:0] drv_rxd = 8'h00;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  task automatic model_step(input logic [31:0] a, input logic wr, input logic [7:0] d);
    logic [17:0] a18;
    bit          io, txpop, rxacc, set_ovf;
    int          idx;
    logic [7:0]  rd;
    exp_t        e;
    a18     = a[17:0];
    io      = (a18[17:16] == 2'b11);
    idx     = int'(a18[16:0]);
    txpop   = drv_txr && (tx_q.size() > 0);
    rxacc   = drv_rxv && (rx_q.size() < RXD);
    set_ovf = 1'b0;
    if (!wr) begin
      if (!io)                  rd = ram_m.exists(idx) ? ram_m[idx] : 8'h00;
      else if (a18 == 18'h30000) rd = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
      else if (a18 == 18'h30004) rd = {5'b0, ovf_m, rx_q.size() > 0, tx_q.size() >= TXD-1};
      else                       rd = 8'h00;
      e.c = cyc + 1;
      e.v = rd;
      exp_q.push_back(e);
    end
    if (txpop) void'(tx_q.pop_front());
    if (wr && !io) ram_m[idx] = d;
    if (wr && a18 == 18'h30000) begin
      if (tx_q.size() < TXD) tx_q.push_back(d);
      else                   set_ovf = 1'b1;
    end
    if (!wr && a18 == 18'h30004) ovf_m = 1'b0;
    if (set_ovf) ovf_m = 1'b1;
    if (!wr && a18 == 18'h30000 && rx_q.size() > 0) void'(rx_q.pop_front());
    if (rxacc) rx_q.push_back(drv_rxd);
  endtask

  task automatic xact(input logic [31:0] a, input logic wr, input logic [7:0] d);
    @(negedge clk);
    mem_a    = a;
    mem_wr   = wr;
    mem_dout = d;
    tx_ready = drv_txr;
    rx_valid = drv_rxv;
    rx_data  = drv_rxd;
    model_step(a, wr, d);
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) xact(32'h0, 1'b0, 8'h00);
  endtask

  task automatic reset_mid();
    @(negedge clk);
    mem_a = '0; mem_wr = 1'b0; mem_dout = '0;
    tx_ready = 1'b0; rx_valid = 1'b0;
    drv_txr = 1'b0; drv_rxv = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_mem_din", mem_din, 8'h00);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_buf_full", io_buffer_full, 1'b0);
    check("rst_rx_ready", rx_ready, 1'b1);
    tx_q.delete(); rx_q.delete(); exp_q.delete();
    ovf_m = 1'b0;
    held  = 8'h00;
    @(posedge clk);
    #3 rst = 1'b0;
  endtask

  // Monitor: every edge, retire due read data or confirm mem_din holds.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      #1;
      if (exp_q.size() > 0 && exp_q[0].c == cyc) begin
        e    = exp_q.pop_front();
        held = e.v;
        check("rd_data", mem_din, e.v);
      end else begin
        check("din_hold", mem_din, held);
      end
      check("tx_valid", tx_valid, tx_q.size() != 0);
      check("tx_data", tx_data, (tx_q.size() > 0) ? tx_q[0] : 8'h00);
      check("buf_full", io_buffer_full, tx_q.size() >= TXD-1);
      check("rx_ready", rx_ready, rx_q.size() != RXD);
    end
  end

  initial begin
    int         kind;
    logic [31:0] a;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;

    for (int i = 0; i < 32; i++) xact(i, 1'b1, 8'($urandom));

    // RAM round-trip and aliasing
    xact(32'h00010, 1'b1, 8'hA5);
    xact(32'h00011, 1'b1, 8'h5A);
    xact(32'h00010, 1'b0, 8'h00);
    xact(32'h00011, 1'b0, 8'h00);
    xact(32'h20004, 1'b1, 8'h3C);
    xact(32'h00004, 1'b0, 8'h00);
    idle(2);

    // TX flow control: 9th byte is dropped, STATUS reports then clears ovf
    for (int i = 0; i < 9; i++) xact(32'h30000, 1'b1, 8'(8'h11 + i));
    xact(32'h30004, 1'b0, 8'h00);
    xact(32'h30004, 1'b0, 8'h00);
    drv_txr = 1'b1;
    idle(10);
    drv_txr = 1'b0;

    // RX path
    drv_rxv = 1'b1; drv_rxd = 8'h41; idle(1);
    drv_rxd = 8'h42; idle(1);
    drv_rxv = 1'b0;
    xact(32'h30004, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) xact(32'h30000, 1'b0, 8'h00);
    drv_rxv = 1'b1;
    for (int i = 0; i < 9; i++) begin drv_rxd = 8'(8'h60 + i); idle(1); end
    drv_rxv = 1'b0;
    for (int i = 0; i < 9; i++) xact(32'h30000, 1'b0, 8'h00);

    // Reset mid-operation with 3 TX and 2 RX bytes resident
    for (int i = 0; i < 3; i++) xact(32'h30000, 1'b1, 8'(8'hC0 + i));
    drv_rxv = 1'b1; drv_rxd = 8'h77; idle(2);
    drv_rxv = 1'b0;
    reset_mid();
    xact(32'h00010, 1'b0, 8'h00);
    idle(1);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      drv_txr = 1'($urandom_range(0, 1));
      drv_rxv = ($urandom_range(0, 2) == 0);
      drv_rxd = 8'($urandom);
      kind    = $urandom_range(0, 7);
      case (kind)
        0, 1, 2: a = {14'h0, 1'($urandom_range(0, 1)), 12'h0, 5'($urandom_range(0, 31))};
        3, 4:    a = 32'h30000;
        5:       a = 32'h30004;
        6:       a = ($urandom_range(0, 1) == 0) ? 32'h30008 : 32'h3FFFF;
        default: a = 32'h0;
      endcase
      xact(a, (kind == 7) ? 1'b0 : 1'($urandom_range(0, 1)), 8'($urandom));
    end
    drv_txr = 1'b0;
    drv_rxv = 1'b0;
    idle(2);
    @(posedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_io_responder.md
# mem_io_responder

Memory-side responder for the CPU's byte-wide memory bus: the far end of the `mem_a`/`mem_wr`/`mem_dout`/`mem_din` protocol driven by the memory controller. It holds a byte-addressed RAM and a small memory-mapped IO window at `mem_a[17:16] == 2'b11`. The IO window contains a UART TX FIFO, which drives `io_buffer_full` back to the controller, and an RX FIFO. It is used as the simulation/FPGA memory model beneath the CPU core.

## Interface
Clock `clk`, reset `rst`; one clock; reset is asynchronous and active-high.

Parameters:
- `ADDR_BITS`, default 17: RAM holds 2^ADDR_BITS bytes, indexed by `mem_a[ADDR_BITS-1:0]`.
- `TX_DEPTH`, default 8: TX FIFO entries. Power of two, ≥ 4.
- `RX_DEPTH`, default 8: RX FIFO entries. Power of two, ≥ 2.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous active-high reset.
- `mem_a`  in  32  byte address from the controller; only bits [17:0] are decoded.
- `mem_wr`  in  1  1 = write cycle, 0 = read cycle.
- `mem_dout`  in  8  write data from the controller.
- `mem_din`  out  8  registered read data to the controller.
- `io_buffer_full`  out  1  TX FIFO near-full flag to the controller.
- `tx_valid`  out  1  TX FIFO non-empty.
- `tx_data`  out  8  TX FIFO head byte.
- `tx_ready`  in  1  UART consumes the head byte when `tx_valid && tx_ready`.
- `rx_valid`  in  1  UART offers a received byte.
- `rx_data`  in  8  received byte.
- `rx_ready`  out  1  RX FIFO not full.

## Operation
- Every rising edge samples `mem_a`, `mem_wr` and `mem_dout`. There is no request/ack handshake; every cycle is a transaction.
- Decode: IO when `mem_a[17:16] == 2'b11`, otherwise RAM. RAM aliases modulo 2^ADDR_BITS.
- RAM write (`mem_wr = 1`, RAM region): `ram[idx] <= mem_dout`. `mem_din` holds its previous value.
- RAM read (`mem_wr = 0`, RAM region): `mem_din <= ram[idx]` (old contents).
- IO addresses are `0x30000` (DATA), `0x30004` (STATUS), and the rest of the IO window.
- IO write, DATA:
  - Pushes `mem_dout` into the TX FIFO if the FIFO is not full.
  - If the FIFO is full, the byte is dropped and the sticky `tx_ovf` flag is set.
- IO write, any other IO address: ignored.
- IO read, DATA:
  - If the RX FIFO is non-empty, `mem_din <=` RX head and the head is popped.
  - If the RX FIFO is empty, `mem_din <= 0` and nothing is popped.
  - Every sampled cycle at DATA with `mem_wr = 0` pops once. A read held N cycles pops N bytes.
- IO read, STATUS: `mem_din <= {5'b0, tx_ovf, rx_count != 0, io_buffer_full}`. The read clears `tx_ovf`. If a set and a clear of `tx_ovf` fall in the same cycle, the set wins.
- IO read, any other IO address: `mem_din <= 0`.
- `io_buffer_full = (tx_count >= TX_DEPTH-1)`, combinational from the registered count. This leaves one slot of slack, because the controller samples the flag one cycle before its registered write reaches this block.
- TX FIFO:
  - `tx_valid = (tx_count != 0)`; `tx_data` = head entry.
  - Pop on `tx_valid && tx_ready`.
  - Push and pop in the same cycle leave the count unchanged, including when full (the pop frees the slot first).
- RX FIFO:
  - `rx_ready = (rx_count != RX_DEPTH)`.
  - Push on `rx_valid && rx_ready`.
  - Simultaneous push and pop are both honoured.
- Pointers are `log2(DEPTH)` bits and wrap naturally. Counts are `log2(DEPTH)+1` bits.

## Timing
- Read latency is 1 cycle. The address sampled at edge k yields its data on `mem_din` after edge k. The controller captures it at edge k+1, which is why its byte index is one behind its address counter.
- Back-to-back reads at incrementing addresses return one byte per cycle. There are no stall states.
- A write takes effect at the sampling edge. A read of the same address at the next edge returns the new byte.
- TX push visibility: a write at edge k shows `tx_valid`/`io_buffer_full` updated after edge k.
- Reset (asynchronous, any cycle, including mid-burst):
  - `mem_din = 0`, `io_buffer_full = 0`, `tx_valid = 0`, `tx_data = 0`, `rx_ready = 1`, `tx_ovf = 0`.
  - FIFO pointers and counts are cleared.
  - RAM contents are not reset.
  - Any in-flight byte is lost; the first post-reset edge is a normal transaction.

## Test plan
- RAM round-trip: write `0xA5` at `0x00010`, then `0x5A` at `0x00011`; read `0x00010`, `0x00011` back-to-back -> `mem_din` is `0xA5` then `0x5A`, each one cycle after its address.
- Aliasing and idle: write `0x3C` at `0x20004` -> a read of `0x00004` returns `0x3C`. Idle `mem_a = 0`, `mem_wr = 0` has no side effects.
- TX flow control (TX_DEPTH = 8, `tx_ready = 0`):
  - 7 writes to `0x30000` -> `io_buffer_full` rises after the 7th.
  - An 8th write is accepted.
  - A 9th write is dropped and STATUS reads `0x05`.
  - A second STATUS read returns `0x01`.
- TX drain: with FIFO contents `0x11`..`0x18`, raise `tx_ready` -> `tx_data` sequence is `0x11`..`0x18`; `tx_valid` falls after 8 pops; `io_buffer_full` falls when `tx_count` reaches 6.
- RX path: push `0x41`, `0x42` via `rx_valid` -> STATUS bit1 = 1. Three DATA reads return `0x41`, `0x42`, `0x00`. Fill 8 bytes -> `rx_ready = 0`.
- Reset mid-operation: assert `rst` asynchronously with 3 bytes in TX and 2 in RX -> all outputs take their reset values immediately. A RAM byte written before reset reads back unchanged.
